onewire_cmd_sched: RTL and testbench
====================================

Name: onewire_cmd_sched

Overview:
- Command scheduler that shares one 1-wire master between N_REQ requesters.
- Round-robin arbitrates pending requests and latches the winner's 56-bit frame.
- Drives the master's transmit start/data and waits for transmit completion.
- Waits for the response frame on the master's receive side, with a timeout, then returns response and status to the granted requester.
- Sits between the system controller and the 1-wire master.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- FRAME_W, 56, frame width in bits, fixed by the 1-wire protocol.
- TIMEOUT_CYC, 100000, clk cycles allowed in WAIT_RX before timeout.
- MAX_RETRY, 2, re-sends after error or timeout (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- i_req  in  N_REQ  per-requester request level; held until that requester's o_done.
- i_req_data  in  N_REQ*FRAME_W  flattened frames; requester k at [k*FRAME_W +: FRAME_W].
- o_grant  out  N_REQ  one-hot; the requester being served.
- o_done  out  N_REQ  one-cycle completion pulse to the served requester.
- o_status  out  2  00 ok, 01 rx error, 10 timeout; valid with o_done, held until the next o_done.
- o_resp  out  FRAME_W  received frame; valid with o_done, held until the next o_done.
- o_busy  out  1  high whenever the state is not IDLE.
- o_tx_data  out  FRAME_W  frame to the master transmitter.
- o_tx_start  out  1  one-cycle start pulse to the transmitter.
- i_tx_busy  in  1  transmitter busy.
- i_tx_done  in  1  transmitter done pulse.
- i_rx_valid  in  1  one-cycle strobe: receiver finished a frame.
- i_rx_command  in  FRAME_W  received frame.
- i_rx_error  in  1  receiver error flag, qualified by i_rx_valid.

Behaviour:
- Reset: state IDLE, all outputs 0, round-robin pointer 0 (requester 0 highest priority), counters 0.
- IDLE:
  - If any i_req bit is set, grant the first set bit at or after the pointer, wrapping.
  - Latch that requester's frame into o_tx_data; set o_grant; go to START.
- START:
  - If i_tx_busy=0, pulse o_tx_start for exactly 1 cycle and go to WAIT_TX.
  - Otherwise hold in START and do not pulse.
- WAIT_TX:
  - On i_tx_done, clear the timeout counter and go to WAIT_RX.
  - i_rx_valid is ignored in this state.
- WAIT_RX:
  - Counter increments every cycle.
  - i_rx_valid=1: latch i_rx_command into o_resp; status = i_rx_error ? 01 : 00; go to DONE.
  - Counter == TIMEOUT_CYC-1 with no i_rx_valid: status 10; o_resp unchanged; go to DONE.
  - i_rx_valid and timeout in the same cycle: i_rx_valid wins.
- DONE:
  - Pulse o_done[granted] for 1 cycle.
  - Pointer = granted index + 1, modulo N_REQ.
  - Clear o_grant; return to IDLE.
  - The next grant occurs no earlier than the cycle after DONE.
- Latency, best case:
  - o_tx_start 2 cycles after i_req rises while idle.
  - o_done 2 cycles after i_rx_valid.
- Requester drops i_req mid-transaction: the transaction still completes and o_done still pulses. A new i_req rising while busy waits for arbitration.
- Changes to i_req_data after grant have no effect; the frame is latched at grant.
- Reset mid-transaction: abort immediately to the reset values above. o_tx_start is never pulsed during reset.
- o_grant is always one-hot or zero. Requesters not granted never see o_done.

Optional Feature:
- Macro: ONEWIRE_SCHED_RETRY_EN.
- Defined:
  - Status 01 or 10 with retry count < MAX_RETRY increments the retry count, re-sends the latched frame (WAIT_RX -> START) and does not pulse o_done.
  - The retry count clears at each grant.
  - After MAX_RETRY re-sends, the final status is reported.
- Undefined:
  - No retry logic or counter is synthesized; every error or timeout goes straight to DONE.

Decomposition:
- Package onewire_pkg holds:
  - FRAME_W = 56.
  - Status codes ST_OK=2'b00, ST_RXERR=2'b01, ST_TIMEOUT=2'b10.
  - State encoding IDLE, START, WAIT_TX, WAIT_RX, DONE.
- Sub-module onewire_rr_arbiter (N_REQ parameter): request vector plus pointer in, one-hot grant and index out. Purely combinational; the pointer register stays in onewire_cmd_sched.

Test Plan:
- Single request: i_req=4'b0001, data 56'h00_A5A5_1234_5678 -> o_tx_data equals data and o_tx_start pulses once. Then tx_done, and rx_valid with command 56'hFF and error=0 -> o_done=4'b0001, o_status=00, o_resp=56'hFF.
- Round robin: i_req=4'b1011 held throughout -> grant order 0, 1, 3, 0 across four transactions, with exactly one o_done per transaction.
- Timeout: TIMEOUT_CYC=16, no i_rx_valid after tx_done -> o_done 17 cycles after tx_done, o_status=10, o_resp unchanged.
- Rx error and simultaneous event: i_rx_valid=1 with i_rx_error=1 on the timeout cycle -> o_status=01. With ONEWIRE_SCHED_RETRY_EN and MAX_RETRY=2, three o_tx_start pulses occur before o_done, which reports status 01.
- Busy transmitter: i_tx_busy=1 for 5 cycles after grant -> no o_tx_start until the cycle after busy falls.
- Reset mid-operation: assert reset in WAIT_RX -> next cycle all outputs 0 and state IDLE. After release, requester 0 is granted first.

Source files
------------

// File: rtl/onewire_pkg.sv
// -----------------------------------------------------------------------------
// onewire_pkg
//   Shared definitions for the 1-wire command scheduler: protocol frame width,
//   completion status codes and the scheduler state encoding.
// -----------------------------------------------------------------------------
package onewire_pkg;

    localparam int FRAME_W = 56;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_RXERR   = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        WAIT_TX = 3'd2,
        WAIT_RX = 3'd3,
        DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/onewire_rr_arbiter.sv
// -----------------------------------------------------------------------------
// onewire_rr_arbiter
//   Combinational round-robin pick: returns the first set request bit at or
//   after ptr_i, wrapping around. The pointer register lives in the caller.
// Ports:
//   req_i   - request vector
//   ptr_i   - highest-priority index this round
//   gnt_o   - one-hot grant (zero when no request)
//   idx_o   - index of the granted requester
//   valid_o - at least one request is pending
// -----------------------------------------------------------------------------
module onewire_rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] ptr_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic [$clog2(N_REQ)-1:0] idx_o,
    output logic                     valid_o
);

    localparam int IW = $clog2(N_REQ);

    always_comb begin
        logic [IW-1:0] k;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        k       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            k = IW'((int'(ptr_i) + i) % N_REQ);
            if (!valid_o && req_i[k]) begin
                valid_o  = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = k;
            end
        end
    end

endmodule

// File: rtl/onewire_cmd_sched.sv
// -----------------------------------------------------------------------------
// onewire_cmd_sched
//   Shares one 1-wire master between N_REQ requesters. A round-robin winner's
//   frame is latched, transmitted, and the response (or a timeout) is returned
//   to that requester with a one-cycle o_done pulse.
//   Optional macro ONEWIRE_SCHED_RETRY_EN: re-send the latched frame up to
//   MAX_RETRY times on rx error or timeout before reporting.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   i_req / i_req_data    - request levels and flattened request frames
//   o_grant / o_done      - one-hot served requester / completion pulse
//   o_status / o_resp     - completion status and response frame
//   o_busy                - scheduler not idle
//   o_tx_data/o_tx_start  - transmitter frame and start pulse
//   i_tx_busy/i_tx_done   - transmitter status
//   i_rx_valid/i_rx_command/i_rx_error - receiver frame strobe, data, error
// -----------------------------------------------------------------------------
module onewire_cmd_sched #(
    parameter int N_REQ       = 4,
    parameter int FRAME_W     = onewire_pkg::FRAME_W,
    parameter int TIMEOUT_CYC = 100000,
    parameter int MAX_RETRY   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [N_REQ*FRAME_W-1:0] i_req_data,
    output logic [N_REQ-1:0]         o_grant,
    output logic [N_REQ-1:0]         o_done,
    output logic [1:0]               o_status,
    output logic [FRAME_W-1:0]       o_resp,
    output logic                     o_busy,
    output logic [FRAME_W-1:0]       o_tx_data,
    output logic                     o_tx_start,
    input  logic                     i_tx_busy,
    input  logic                     i_tx_done,
    input  logic                     i_rx_valid,
    input  logic [FRAME_W-1:0]       i_rx_command,
    input  logic                     i_rx_error
);

    import onewire_pkg::*;

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d, done_q, done_d;
    logic [IW-1:0]      ptr_q, ptr_d, gidx_q, gidx_d;
    logic [FRAME_W-1:0] tx_data_q, tx_data_d, resp_q, resp_d;
    logic               tx_start_q, tx_start_d;
    logic [1:0]         status_q, status_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic [N_REQ-1:0]   arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic               arb_valid;
    logic               timeout, rx_event, rx_fail, retry_take;

    onewire_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req_i   (i_req),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // A received frame wins over a timeout landing on the same cycle.
    assign timeout  = (cnt_q == CW'(TIMEOUT_CYC - 1));
    assign rx_event = i_rx_valid || timeout;
    assign rx_fail  = i_rx_valid ? i_rx_error : timeout;

`ifdef ONEWIRE_SCHED_RETRY_EN
    localparam int RW = $clog2(MAX_RETRY + 2);
    logic [RW-1:0] retry_q;

    assign retry_take = rx_fail && (retry_q < RW'(MAX_RETRY));

    always_ff @(posedge clk) begin
        if (reset)
            retry_q <= '0;
        else if (state_q == IDLE && arb_valid)
            retry_q <= '0;
        else if (state_q == WAIT_RX && rx_event && retry_take)
            retry_q <= retry_q + RW'(1);
    end
`else
    // Retries compiled out; the MAX_RETRY term folds to zero.
    assign retry_take = rx_fail & (MAX_RETRY < 0);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (arb_valid)  state_d = START;
            START:   if (!i_tx_busy) state_d = WAIT_TX;
            WAIT_TX: if (i_tx_done)  state_d = WAIT_RX;
            WAIT_RX: if (rx_event)   state_d = retry_take ? START : DONE;
            DONE:                    state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Output / datapath next-state logic
    always_comb begin
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        ptr_d      = ptr_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        done_d     = '0;
        status_d   = status_q;
        resp_d     = resp_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_d   = arb_gnt;
                    gidx_d    = arb_idx;
                    tx_data_d = i_req_data[int'(arb_idx)*FRAME_W +: FRAME_W];
                end
            end
            START: begin
                if (!i_tx_busy) tx_start_d = 1'b1;
            end
            WAIT_TX: begin
                if (i_tx_done) cnt_d = '0;
            end
            WAIT_RX: begin
                cnt_d = cnt_q + CW'(1);
                // Status/response change only on the reported attempt so they
                // stay stable between o_done pulses.
                if (rx_event && !retry_take) begin
                    if (i_rx_valid) begin
                        resp_d   = i_rx_command;
                        status_d = i_rx_error ? ST_RXERR : ST_OK;
                    end else begin
                        status_d = ST_TIMEOUT;
                    end
                end
            end
            DONE: begin
                done_d  = grant_q;
                grant_d = '0;
                ptr_d   = (gidx_q == IW'(N_REQ - 1)) ? '0 : gidx_q + IW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q    <= '0;
            gidx_q     <= '0;
            ptr_q      <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            done_q     <= '0;
            status_q   <= ST_OK;
            resp_q     <= '0;
            cnt_q      <= '0;
        end else begin
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            ptr_q      <= ptr_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            done_q     <= done_d;
            status_q   <= status_d;
            resp_q     <= resp_d;
            cnt_q      <= cnt_d;
        end
    end

    assign o_grant    = grant_q;
    assign o_done     = done_q;
    assign o_status   = status_q;
    assign o_resp     = resp_q;
    assign o_busy     = (state_q != IDLE);
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;

endmodule

// File: tb/tb_onewire_cmd_sched.sv
// -----------------------------------------------------------------------------
// tb_onewire_cmd_sched
//   Directed bench for onewire_cmd_sched (N_REQ=4, TIMEOUT_CYC=16).
//   Honours ONEWIRE_SCHED_RETRY_EN: with it, error/timeout transactions take
//   three attempts before o_done.
// -----------------------------------------------------------------------------
module tb_onewire_cmd_sched;

    localparam int N  = 4;
    localparam int FW = 56;
`ifdef ONEWIRE_SCHED_RETRY_EN
    localparam int ATT = 3;
`else
    localparam int ATT = 1;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    i_req;
    logic [N*FW-1:0] i_req_data;
    logic [N-1:0]    o_grant, o_done;
    logic [1:0]      o_status;
    logic [FW-1:0]   o_resp, o_tx_data, i_rx_command;
    logic            o_busy, o_tx_start, i_tx_busy, i_tx_done, i_rx_valid, i_rx_error;

    int errors = 0;
    int checks = 0;
    int start_cnt = 0;
    int done_cnt = 0;

    onewire_cmd_sched #(.N_REQ(N), .FRAME_W(FW), .TIMEOUT_CYC(16), .MAX_RETRY(2)) dut (
        .clk(clk), .reset(reset), .i_req(i_req), .i_req_data(i_req_data),
        .o_grant(o_grant), .o_done(o_done), .o_status(o_status), .o_resp(o_resp),
        .o_busy(o_busy), .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
        .i_tx_busy(i_tx_busy), .i_tx_done(i_tx_done), .i_rx_valid(i_rx_valid),
        .i_rx_command(i_rx_command), .i_rx_error(i_rx_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_tx_start)  start_cnt <= start_cnt + 1;
        if (o_done != 0) done_cnt  <= done_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // sel: 0 grant, 1 tx_start, 2 done. n = steps taken (50 means it never came).
    task automatic wait_for(input int sel, output int n);
        logic hit;
        n = 0;
        while (n < 50) begin
            case (sel)
                0:       hit = |o_grant;
                1:       hit = o_tx_start;
                default: hit = |o_done;
            endcase
            if (hit) break;
            step(1);
            n++;
        end
    endtask

    initial begin
        int n, s0, d0;
        logic [N-1:0]  rr_exp [4];
        logic [FW-1:0] rr_cmd [4];
        rr_exp = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
        rr_cmd = '{56'h11, 56'h22, 56'h33, 56'h44};

        reset = 1'b1; i_req = '0; i_req_data = '0; i_tx_busy = 1'b0; i_tx_done = 1'b0;
        i_rx_valid = 1'b0; i_rx_command = '0; i_rx_error = 1'b0;
        step(3);
        chk("rst_grant",   64'(o_grant), 0);
        chk("rst_done",    64'(o_done), 0);
        chk("rst_busy",    64'(o_busy), 0);
        chk("rst_txstart", 64'(o_tx_start), 0);
        chk("rst_txdata",  64'(o_tx_data), 0);
        chk("rst_status",  64'(o_status), 0);
        chk("rst_resp",    64'(o_resp), 0);
        reset = 1'b0;
        step(1);

        // ---- single request ----
        i_req_data[0*FW +: FW] = 56'h00_A5A5_1234_5678;
        i_req_data[2*FW +: FW] = 56'hC0_FFEE;
        i_req = 4'b0001;
        s0 = start_cnt;
        step(1);
        chk("t1_grant",       64'(o_grant), 4'b0001);
        chk("t1_busy",        64'(o_busy), 1);
        chk("t1_start_early", 64'(o_tx_start), 0);
        i_req_data[0*FW +: FW] = 56'h0;              // after grant: must not matter
        step(1);
        chk("t1_start",  64'(o_tx_start), 1);
        chk("t1_txdata", 64'(o_tx_data), 56'h00_A5A5_1234_5678);
        step(1);
        chk("t1_start_once", 64'(o_tx_start), 0);
        i_tx_done = 1'b1; step(1); i_tx_done = 1'b0;
        i_rx_valid = 1'b1; i_rx_command = 56'hFF; i_rx_error = 1'b0;
        step(1);
        i_rx_valid = 1'b0; i_req = '0;
        chk("t1_done_early", 64'(o_done), 0);
        step(1);
        chk("t1_done",   64'(o_done), 4'b0001);
        chk("t1_status", 64'(o_status), 2'b00);
        chk("t1_resp",   64'(o_resp), 56'hFF);
        chk("t1_gclr",   64'(o_grant), 0);
        step(1);
        chk("t1_done_pulse", 64'(o_done), 0);
        chk("t1_starts",     64'(start_cnt - s0), 1);

        // ---- round robin from a fresh pointer ----
        reset = 1'b1; step(2); reset = 1'b0;
        i_req = 4'b1011;
        d0 = done_cnt;
        for (int t = 0; t < 4; t++) begin
            wait_for(0, n);
            chk($sformatf("rr%0d_grant", t), 64'(o_grant), 64'(rr_exp[t]));
            wait_for(1, n);
            step(1); i_tx_done = 1'b1; step(1); i_tx_done = 1'b0;
            i_rx_valid = 1'b1; i_rx_command = rr_cmd[t]; step(1); i_rx_valid = 1'b0;
            wait_for(2, n);
            chk($sformatf("rr%0d_done", t), 64'(o_done), 64'(rr_exp[t]));
        end
        i_req = '0;
        step(1);
        chk("rr_done_count", 64'(done_cnt - d0), 4);

        // ---- timeout (pointer now 1, requester 2 alone) ----
        i_req = 4'b0100;
        s0 = start_cnt;
        wait_for(0, n);
        chk("to_grant", 64'(o_grant), 4'b0100);
        for (int a = 0; a < ATT; a++) begin
            wait_for(1, n);
            i_rx_valid = 1'b1; i_rx_command = 56'hDEAD; step(1); i_rx_valid = 1'b0;
            i_tx_done = 1'b1; step(1); i_tx_done = 1'b0;
            if (a == ATT - 1) begin
                wait_for(2, n);
                chk("to_latency", 64'(n), 17);
            end
        end
        chk("to_done",   64'(o_done), 4'b0100);
        chk("to_status", 64'(o_status), 2'b10);
        chk("to_resp",   64'(o_resp), 56'h44);
        i_req = '0;
        step(1);
        chk("to_starts", 64'(start_cnt - s0), 64'(ATT));

        // ---- rx error on the timeout cycle (pointer now 3) ----
        i_req = 4'b1000;
        s0 = start_cnt;
        wait_for(0, n);
        chk("sim_grant", 64'(o_grant), 4'b1000);
        for (int a = 0; a < ATT; a++) begin
            wait_for(1, n);
            step(1); i_tx_done = 1'b1; step(1); i_tx_done = 1'b0;
            if (a == 0) step(15);
            i_rx_valid = 1'b1; i_rx_error = 1'b1; i_rx_command = 56'hABC;
            step(1);
            i_rx_valid = 1'b0; i_rx_error = 1'b0;
        end
        wait_for(2, n);
        chk("sim_done",   64'(o_done), 4'b1000);
        chk("sim_status", 64'(o_status), 2'b01);
        chk("sim_resp",   64'(o_resp), 56'hABC);
        i_req = '0;
        step(1);
        chk("sim_starts", 64'(start_cnt - s0), 64'(ATT));

        // ---- busy transmitter, requester drops i_req after grant ----
        i_req = 4'b0001; i_tx_busy = 1'b1;
        i_req_data[0*FW +: FW] = 56'h1234;
        step(1);
        chk("bz_grant",  64'(o_grant), 4'b0001);
        chk("bz_start0", 64'(o_tx_start), 0);
        i_req = '0;
        for (int c = 0; c < 5; c++) begin
            step(1);
            chk($sformatf("bz_hold%0d", c), 64'(o_tx_start), 0);
        end
        i_tx_busy = 1'b0;
        step(1);
        chk("bz_start",  64'(o_tx_start), 1);
        chk("bz_txdata", 64'(o_tx_data), 56'h1234);
        step(1); i_tx_done = 1'b1; step(1); i_tx_done = 1'b0;
        i_rx_valid = 1'b1; i_rx_command = 56'h77; step(1); i_rx_valid = 1'b0;
        wait_for(2, n);
        chk("bz_done",   64'(o_done), 4'b0001);
        chk("bz_status", 64'(o_status), 2'b00);
        step(1);

        // ---- reset in WAIT_RX (pointer now 1) ----
        i_req = 4'b0100;
        wait_for(0, n);
        chk("rs_grant0", 64'(o_grant), 4'b0100);
        wait_for(1, n);
        step(1); i_tx_done = 1'b1; step(1); i_tx_done = 1'b0;
        step(2);
        reset = 1'b1; i_req = 4'b0101;
        step(1);
        chk("rs_grant",   64'(o_grant), 0);
        chk("rs_busy",    64'(o_busy), 0);
        chk("rs_txdata",  64'(o_tx_data), 0);
        chk("rs_resp",    64'(o_resp), 0);
        chk("rs_status",  64'(o_status), 0);
        chk("rs_done",    64'(o_done), 0);
        chk("rs_txstart", 64'(o_tx_start), 0);
        step(2);
        chk("rs_hold_start", 64'(o_tx_start), 0);
        reset = 1'b0;
        step(1);
        chk("rs_regrant", 64'(o_grant), 4'b0001);
        i_req = '0;
        reset = 1'b1; step(2); reset = 1'b0; step(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
